issue_scoreboard: RTL and testbench

- Issue-stage scoreboard for the pipelined MIPS core.
- Tracks GPRs with an outstanding write from long-latency units (load miss path, mult/div), and holds decode until RAW/WAW hazards clear.
- Short ALU results are covered by forwarding and never tracked.
- Decode drives register-usage flags per instruction; writeback ports retire pending writes.

---
 rtl/issue_scoreboard_pkg.sv | 17 +
 rtl/issue_scoreboard_hazard.sv | 42 ++++
 rtl/issue_scoreboard.sv | 111 +++++++++++
 tb/tb_issue_scoreboard.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared types and defaults for the issue-stage scoreboard.
// Sizes here match the 32-GPR MIPS register file.
package issue_scoreboard_pkg;

    localparam int NREG_DEF    = 32;
    localparam int MAX_OUT_DEF = 4;
    localparam int CNT_W_DEF   = 32;
    localparam int REG_W       = $clog2(NREG_DEF);
    localparam int OUT_W       = 3;

    typedef struct packed {
        logic raw;
        logic waw;
        logic full;
    } hazard_t;

endpackage

// File: rtl/issue_scoreboard_hazard.sv
// Combinational RAW/WAW/capacity check for the instruction in decode.
// A same-cycle writeback is treated as already resolved.
module sb_hazard_check
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic [NREG-1:0]  pending,
    input  logic [OUT_W-1:0] outstanding,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_long,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_reg,
    output hazard_t          haz
);

    localparam logic [OUT_W-1:0] MAX_V = OUT_W'(MAX_OUT);

    logic [NREG-1:0] wb_mask;
    logic [NREG-1:0] eff;

    always_comb begin
        wb_mask = '0;
        if (wb_valid) begin
            wb_mask[wb_reg] = 1'b1;
        end
        eff    = pending & ~wb_mask;
        // r0 is hardwired, so it can never hold a hazard
        eff[0] = 1'b0;

        haz.raw  = (id_use_rs & eff[id_rs]) | (id_use_rt & eff[id_rt]);
        haz.waw  = id_wr_en & eff[id_wr_reg];
        haz.full = id_long & id_wr_en & (outstanding == MAX_V) & ~wb_valid;
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks GPRs awaiting long-latency results and
// holds decode until RAW/WAW hazards and in-flight capacity clear.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_long,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_reg,
    output logic [NREG-1:0]  pending,
    output logic [OUT_W-1:0] outstanding,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             sb_err
);

    localparam logic [OUT_W-1:0] MAX_V = OUT_W'(MAX_OUT);

    hazard_t          haz;
    logic [NREG-1:0]  pending_q, pending_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             sb_err_q, sb_err_d;
    logic             issue, long_issue, wb_err, wb_ok, inc, dec;

    sb_hazard_check #(
        .NREG   (NREG),
        .MAX_OUT(MAX_OUT)
    ) u_hazard (
        .pending    (pending_q),
        .outstanding(outstanding_q),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wr_en   (id_wr_en),
        .id_wr_reg  (id_wr_reg),
        .id_long    (id_long),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .haz        (haz)
    );

    assign id_ready = ~(haz.raw | haz.waw | haz.full);

    always_comb begin
        issue      = id_valid & id_ready;
        long_issue = issue & id_wr_en & id_long;
        wb_err     = wb_valid & ((((wb_reg != '0) & ~pending_q[wb_reg]))
                                 | (outstanding_q == '0));
        wb_ok      = wb_valid & ~wb_err;
        dec        = wb_ok;
        inc        = long_issue & (wb_ok | (outstanding_q != MAX_V));

        // clear before set so a new producer wins over the retiring one
        pending_d = pending_q;
        if (wb_ok) begin
            pending_d[wb_reg] = 1'b0;
        end
        if (long_issue) begin
            pending_d[id_wr_reg] = 1'b1;
        end
        pending_d[0] = 1'b0;

        outstanding_d = outstanding_q;
        if (inc && !dec) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (dec && !inc) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        if (id_valid && !id_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        sb_err_d = sb_err_q | wb_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            stall_cnt_q   <= '0;
            sb_err_q      <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            stall_cnt_q   <= stall_cnt_d;
            sb_err_q      <= sb_err_d;
        end
    end

    assign pending     = pending_q;
    assign outstanding = outstanding_q;
    assign stall_cnt   = stall_cnt_q;
    assign sb_err      = sb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: stimulus queues expected
// outputs, a negedge monitor pops and compares them.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs, id_rt, id_wr_reg, wb_reg;
    logic        id_use_rs, id_use_rt, id_wr_en, id_long, wb_valid;
    logic [31:0] pending;
    logic [2:0]  outstanding;
    logic [31:0] stall_cnt;
    logic        sb_err;

    typedef struct {
        string       name;
        logic        rdy;
        logic [31:0] pend;
        logic [2:0]  outs;
        logic [31:0] stall;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    issue_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_wr_en   (id_wr_en),
        .id_wr_reg  (id_wr_reg),
        .id_long    (id_long),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .pending    (pending),
        .outstanding(outstanding),
        .stall_cnt  (stall_cnt),
        .sb_err     (sb_err)
    );

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s.%s: got %0h want %0h", nm, fld, got, want);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "id_ready", 32'(id_ready), 32'(e.rdy));
            cmp(e.name, "pending", pending, e.pend);
            cmp(e.name, "outstanding", 32'(outstanding), 32'(e.outs));
            cmp(e.name, "stall_cnt", stall_cnt, e.stall);
            cmp(e.name, "sb_err", 32'(sb_err), 32'(e.err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_wr_en = 0; id_wr_reg = 0; id_long = 0; wb_valid = 0; wb_reg = 0;
    endtask

    task automatic iss(input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic we, input logic [4:0] wr,
                       input logic lng);
        id_valid = 1; id_rs = rs; id_use_rs = urs; id_rt = rt;
        id_use_rt = urt; id_wr_en = we; id_wr_reg = wr; id_long = lng;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1; wb_reg = r;
    endtask

    task automatic expect_o(input string nm, input logic rdy,
                            input logic [31:0] pend, input logic [2:0] outs,
                            input logic [31:0] stall, input logic err);
        exp_t e;
        e.name = nm; e.rdy = rdy; e.pend = pend; e.outs = outs;
        e.stall = stall; e.err = err;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        idle();
        cyc();
        expect_o("reset", 1, 0, 0, 0, 0);
        cyc();
        reset = 0;

        // RAW stall on a long load, resolved by same-cycle writeback
        cyc(); idle(); iss(0, 0, 0, 0, 1, 8, 1);
        expect_o("ld_r8", 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); idle(); iss(8, 1, 0, 0, 1, 10, 0);
            expect_o("raw_r8", 0, 32'h100, 1, 32'(i), 0);
        end
        cyc(); idle(); iss(8, 1, 0, 0, 1, 10, 0); wb(8);
        expect_o("wb_byp_r8", 1, 32'h100, 1, 3, 0);
        cyc(); idle();
        expect_o("r8_clear", 1, 0, 0, 3, 0);

        // fill MAX_OUT, fifth blocks, fifth plus writeback issues
        cyc(); idle(); iss(0, 0, 0, 0, 1, 1, 1);
        expect_o("fill_r1", 1, 0, 0, 3, 0);
        cyc(); idle(); iss(0, 0, 0, 0, 1, 2, 1);
        expect_o("fill_r2", 1, 32'h2, 1, 3, 0);
        cyc(); idle(); iss(0, 0, 0, 0, 1, 3, 1);
        expect_o("fill_r3", 1, 32'h6, 2, 3, 0);
        cyc(); idle(); iss(0, 0, 0, 0, 1, 4, 1);
        expect_o("fill_r4", 1, 32'hE, 3, 3, 0);
        cyc(); idle(); iss(0, 0, 0, 0, 1, 5, 1);
        expect_o("full_r5", 0, 32'h1E, 4, 3, 0);
        cyc(); idle(); iss(0, 0, 0, 0, 1, 5, 1); wb(1);
        expect_o("full_wb_r5", 1, 32'h1E, 4, 4, 0);
        cyc(); idle();
        expect_o("after_swap", 1, 32'h3C, 4, 4, 0);
        cyc(); idle(); wb(2);
        expect_o("drain_r2", 1, 32'h3C, 4, 4, 0);
        cyc(); idle(); wb(3);
        expect_o("drain_r3", 1, 32'h38, 3, 4, 0);
        cyc(); idle(); wb(4);
        expect_o("drain_r4", 1, 32'h30, 2, 4, 0);
        cyc(); idle(); wb(5);
        expect_o("drain_r5", 1, 32'h20, 1, 4, 0);
        cyc(); idle();
        expect_o("drained", 1, 0, 0, 4, 0);

        // WAW on r9, then writeback and re-issue in the same cycle
        cyc(); idle(); iss(0, 0, 0, 0, 1, 9, 1);
        expect_o("ld_r9", 1, 0, 0, 4, 0);
        cyc(); idle(); iss(0, 0, 0, 0, 1, 9, 1);
        expect_o("waw_r9", 0, 32'h200, 1, 4, 0);
        cyc(); idle(); iss(0, 0, 0, 0, 1, 9, 1); wb(9);
        expect_o("waw_wb_r9", 1, 32'h200, 1, 5, 0);
        cyc(); idle();
        expect_o("r9_reset_wins", 1, 32'h200, 1, 5, 0);
        cyc(); idle(); wb(9);
        expect_o("wb_r9", 1, 32'h200, 1, 5, 0);
        cyc(); idle();
        expect_o("r9_done", 1, 0, 0, 5, 0);

        // unused register fields never stall
        cyc(); idle(); iss(0, 0, 0, 0, 1, 31, 1);
        expect_o("ld_r31", 1, 0, 0, 5, 0);
        cyc(); idle(); iss(31, 0, 31, 0, 0, 31, 0);
        expect_o("jump", 1, 32'h8000_0000, 1, 5, 0);
        cyc(); idle(); iss(4, 1, 31, 0, 0, 0, 0);
        expect_o("regimm", 1, 32'h8000_0000, 1, 5, 0);
        cyc(); idle(); wb(31);
        expect_o("wb_r31", 1, 32'h8000_0000, 1, 5, 0);
        cyc(); idle();
        expect_o("r31_done", 1, 0, 0, 5, 0);

        // r0 destination counts as in flight but is never pending
        cyc(); idle(); iss(0, 0, 0, 0, 1, 0, 1);
        expect_o("ld_r0", 1, 0, 0, 5, 0);
        cyc(); idle(); iss(0, 1, 0, 1, 1, 0, 0);
        expect_o("read_r0", 1, 0, 1, 5, 0);
        cyc(); idle(); wb(0);
        expect_o("wb_r0", 1, 0, 1, 5, 0);
        cyc(); idle();
        expect_o("r0_done", 1, 0, 0, 5, 0);

        // spurious writeback sets the sticky error
        cyc(); idle(); wb(7);
        expect_o("bad_wb_r7", 1, 0, 0, 5, 0);
        cyc(); idle();
        expect_o("err_set", 1, 0, 0, 5, 1);
        cyc(); idle();
        expect_o("err_sticky", 1, 0, 0, 5, 1);

        // async reset in the middle of a stall
        cyc(); idle(); iss(0, 0, 0, 0, 1, 12, 1);
        expect_o("ld_r12", 1, 0, 0, 5, 1);
        cyc(); idle(); iss(12, 1, 0, 0, 1, 13, 0);
        expect_o("raw_r12_a", 0, 32'h1000, 1, 5, 1);
        cyc(); idle(); iss(12, 1, 0, 0, 1, 13, 0);
        expect_o("raw_r12_b", 0, 32'h1000, 1, 6, 1);
        cyc();
        #2 reset = 1;
        expect_o("async_rst", 1, 0, 0, 0, 0);
        cyc();
        reset = 0;
        idle();
        expect_o("post_rst", 1, 0, 0, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
